cnt4_run_ctrl: RTL and testbench
================================

CNT4_RUN_CTRL -- requirements
Module: cnt4_run_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, default 4, width of counter, limit and repeat fields.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  run request, sampled in IDLE only.
REQ-005 SHALL have port: stop  input  1  abort request, highest priority among start, stop and pause.
REQ-006 SHALL have port: cfg_limit  input  CNT_W  terminal count, latched at start.
REQ-007 SHALL have port: cfg_reps  input  CNT_W  extra passes after the first, latched at start.
REQ-008 SHALL have port: pause  input  1  hold request; present only with CNT_CTRL_PAUSE_EN.
REQ-009 SHALL have port: cnt  output  CNT_W  registered count value.
REQ-010 SHALL have port: ack  output  1  registered pulse, high in first RUN cycle after start accepted.
REQ-011 SHALL have port: busy  output  1  high while state is RUN or PAUSE.
REQ-012 SHALL have port: tick  output  1  registered one-cycle pulse, high in the cycle after each wrap.
REQ-013 SHALL have port: done  output  1  registered one-cycle pulse, high in the DONE state.
REQ-014 SHALL have port: rep_left  output  CNT_W  remaining extra passes.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE, plus PAUSE when CNT_CTRL_PAUSE_EN is defined.
REQ-016 In IDLE with start=1 and stop=0, SHALL latch cfg_limit into lim_q and cfg_reps into rep_left, clear cnt and enter RUN.
REQ-017 In IDLE, cnt SHALL hold at 0; start and stop high together SHALL leave the block in IDLE.
REQ-018 In RUN with stop=0 and pause=0, cnt SHALL increment by 1 per clock while cnt is not equal to lim_q.
REQ-019 A wrap event SHALL occur when cnt==lim_q in RUN with stop=0 and pause=0: cnt becomes 0 and tick is high next cycle.
REQ-020 At a wrap with rep_left!=0, rep_left SHALL decrement and the state SHALL stay RUN.
REQ-021 At a wrap with rep_left==0, the state SHALL become DONE; pass length is lim_q+1 cycles, and total passes are cfg_reps+1.
REQ-022 cfg_limit=0 SHALL wrap every cycle; cfg_limit=2^CNT_W-1 SHALL count through the full range.
REQ-023 DONE SHALL last exactly one cycle (done=1, cnt=0, busy=0), then return to IDLE; start in DONE SHALL be ignored.
REQ-024 stop=1 in RUN or PAUSE SHALL enter IDLE next cycle with cnt=0 and rep_left=0, and SHALL assert neither done nor tick, even on a would-be wrap cycle.
REQ-025 Changes to cfg_limit and cfg_reps while busy=1 SHALL have no effect until the next accepted start.
REQ-026 start while busy=1 SHALL be ignored, and ack SHALL not assert.

Reset
REQ-027 reset_n=0 SHALL immediately, without a clock edge, force IDLE with cnt=0, lim_q=0, rep_left=0, ack=0, busy=0, tick=0, done=0.
REQ-028 Reset asserted mid-run SHALL abort with no done or tick pulse; operation SHALL resume only on a start accepted after reset_n=1.

Configuration
REQ-029 Macro CNT_CTRL_PAUSE_EN defined: pause=1 in RUN SHALL enter PAUSE with cnt, rep_left and lim_q held and no wrap evaluated.
REQ-030 With CNT_CTRL_PAUSE_EN defined, PAUSE with pause=0 SHALL behave as a RUN cycle (advance or wrap) and return to RUN; busy SHALL remain 1 in PAUSE.
REQ-031 Macro CNT_CTRL_PAUSE_EN undefined: the pause port and the PAUSE state SHALL be absent, and behaviour SHALL equal the macro-defined behaviour with pause tied to 0.

Verification
REQ-032 Limit 3, reps 1, start accepted at edge E0: ack=1 after E0; cnt 0,1,2,3,0,1,2,3; tick after E4 and E8; done=1 after E8 only; busy high 8 cycles.
REQ-033 Limit 0, reps 0, start: one RUN cycle with cnt=0; then DONE with tick=1 and done=1; then IDLE.
REQ-034 Limit 5, stop at cnt=2: IDLE next cycle, cnt=0, busy=0, no done or tick; a following start restarts from 0.
REQ-035 Limit 3, reps 0, stop in the cycle where cnt=3: no tick, no done, IDLE next cycle.
REQ-036 Limit 7, reset_n low mid-edge-interval at cnt=4: cnt=0 and busy=0 before the next clk edge; no done after release.
REQ-037 With CNT_CTRL_PAUSE_EN: limit 3, reps 0, pause high for 3 edges starting at cnt=1: cnt holds at 1; done is delayed exactly 3 cycles versus REQ-033 timing scaled to limit 3.

Source files
------------

// File: rtl/cnt4_run_ctrl.sv
// Run controller: counts 0..limit for (reps+1) passes, pulsing tick on each wrap and done at the end.
// Optional hold state is compiled in when CNT_CTRL_PAUSE_EN is defined.
module cnt4_run_ctrl #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] cfg_limit_i,
    input  logic [CNT_W-1:0] cfg_reps_i,
`ifdef CNT_CTRL_PAUSE_EN
    input  logic             pause_i,
`endif
    output logic [CNT_W-1:0] cnt_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             done_o,
    output logic [CNT_W-1:0] rep_left_o
);

`ifdef CNT_CTRL_PAUSE_EN
    typedef enum logic [1:0] {StIdle, StRun, StDone, StPause} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             ack_q, ack_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lim_q   <= '0;
            rep_q   <= '0;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            rep_q   <= rep_d;
            ack_q   <= ack_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        rep_d   = rep_q;
        ack_d   = 1'b0;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_i && !stop_i) begin
                    lim_d   = cfg_limit_i;
                    rep_d   = cfg_reps_i;
                    ack_d   = 1'b1;
                    state_d = StRun;
                end
            end
`ifdef CNT_CTRL_PAUSE_EN
            StRun, StPause: begin
`else
            StRun: begin
`endif
                // Stop wins over a coinciding wrap: no tick, no done.
                if (stop_i) begin
                    cnt_d   = '0;
                    rep_d   = '0;
                    state_d = StIdle;
                end
`ifdef CNT_CTRL_PAUSE_EN
                else if (pause_i) begin
                    state_d = StPause;
                end
`endif
                else if (cnt_q == lim_q) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (rep_q != '0) begin
                        rep_d   = rep_q - CNT_W'(1);
                        state_d = StRun;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StRun;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                rep_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign cnt_o      = cnt_q;
    assign rep_left_o = rep_q;
    assign ack_o      = ack_q;
    assign tick_o     = tick_q;
    assign done_o     = (state_q == StDone);
`ifdef CNT_CTRL_PAUSE_EN
    assign busy_o     = (state_q == StRun) || (state_q == StPause);
`else
    assign busy_o     = (state_q == StRun);
`endif

endmodule

// File: tb/tb_cnt4_run_ctrl.sv
// Bench for cnt4_run_ctrl: vector table, corner-case sequences, then random stimulus vs a
// position-in-run reference model. Follows CNT_CTRL_PAUSE_EN like the design.
`timescale 1ns/1ps
module tb_cnt4_run_ctrl;
    localparam int unsigned CNT_W = 4;
`ifdef CNT_CTRL_PAUSE_EN
    localparam bit PauseEn = 1'b1;
`else
    localparam bit PauseEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n, start, stop, pause;
    logic [CNT_W-1:0] cfg_limit, cfg_reps;
    logic [CNT_W-1:0] cnt, rep_left;
    logic             ack, busy, tick, done;

    int total = 0;
    int bad   = 0;

    cnt4_run_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .start_i    (start),
        .stop_i     (stop),
        .cfg_limit_i(cfg_limit),
        .cfg_reps_i (cfg_reps),
`ifdef CNT_CTRL_PAUSE_EN
        .pause_i    (pause),
`endif
        .cnt_o      (cnt),
        .ack_o      (ack),
        .busy_o     (busy),
        .tick_o     (tick),
        .done_o     (done),
        .rep_left_o (rep_left)
    );

    always #5 clk = ~clk;

    // Model: a run is a sequence of k = 0..(lim+1)*(reps+1) advancing cycles.
    int m_phase;  // 0 idle, 1 running (or held), 2 done
    int m_k, m_lim, m_reps;
    bit m_ack, m_tick;

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_lim = 0; m_reps = 0; m_ack = 1'b0; m_tick = 1'b0;
    endtask

    task automatic model_step();
        m_ack  = 1'b0;
        m_tick = 1'b0;
        case (m_phase)
            1: begin
                if (stop) begin
                    m_phase = 0;
                end else if (!(PauseEn && pause)) begin
                    m_k++;
                    if (m_k % (m_lim + 1) == 0) m_tick = 1'b1;
                    if (m_k == (m_lim + 1) * (m_reps + 1)) m_phase = 2;
                end
            end
            2: m_phase = 0;
            default: begin
                if (start && !stop) begin
                    m_phase = 1;
                    m_k     = 0;
                    m_lim   = int'(cfg_limit);
                    m_reps  = int'(cfg_reps);
                    m_ack   = 1'b1;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int e_cnt, e_rep;
        e_cnt = (m_phase == 1) ? m_k % (m_lim + 1) : 0;
        e_rep = (m_phase == 1) ? m_reps - m_k / (m_lim + 1) : 0;
        check({tag, "_cnt"},  int'(cnt),      e_cnt);
        check({tag, "_rep"},  int'(rep_left), e_rep);
        check({tag, "_ack"},  int'(ack),      int'(m_ack));
        check({tag, "_busy"}, int'(busy),     int'(m_phase == 1));
        check({tag, "_tick"}, int'(tick),     int'(m_tick));
        check({tag, "_done"}, int'(done),     int'(m_phase == 2));
    endtask

    // Inputs are set at the falling edge, sampled at the rising edge, outputs checked at the next fall.
    task automatic clk_step(input bit use_model);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (use_model) check_model("rnd");
    endtask

    typedef struct {
        int st, sp, lim, reps;
        int e_cnt, e_rep, e_ack, e_busy, e_tick, e_done;
    } vec_t;
    vec_t vecs[11];

    initial begin
        // limit 3, reps 1; cfg changes and start pulses while busy must be ignored
        vecs[0]  = '{1, 0, 3, 1,  0, 1, 1, 1, 0, 0};
        vecs[1]  = '{0, 0, 9, 5,  1, 1, 0, 1, 0, 0};
        vecs[2]  = '{1, 0, 9, 5,  2, 1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 9, 5,  3, 1, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 2,  0, 0, 0, 1, 1, 0};
        vecs[5]  = '{0, 0, 1, 2,  1, 0, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 1, 2,  2, 0, 0, 1, 0, 0};
        vecs[7]  = '{0, 0, 1, 2,  3, 0, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 1, 2,  0, 0, 0, 0, 1, 1};
        vecs[9]  = '{1, 0, 2, 0,  0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 2, 0,  0, 0, 0, 0, 0, 0};

        start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfg_limit = '0; cfg_reps = '0;
        reset_n = 1'b0;
        model_reset();
        #12;
        check("rst_cnt",  int'(cnt),      0);
        check("rst_rep",  int'(rep_left), 0);
        check("rst_ack",  int'(ack),      0);
        check("rst_busy", int'(busy),     0);
        check("rst_tick", int'(tick),     0);
        check("rst_done", int'(done),     0);
        reset_n = 1'b1;
        @(negedge clk);

        // start+stop together stays idle
        start = 1'b1; stop = 1'b1; cfg_limit = 4'd3;
        clk_step(1'b0);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", int'(busy), 0);
        check("ss_ack",  int'(ack),  0);

        foreach (vecs[i]) begin
            start     = (vecs[i].st != 0);
            stop      = (vecs[i].sp != 0);
            cfg_limit = CNT_W'(vecs[i].lim);
            cfg_reps  = CNT_W'(vecs[i].reps);
            clk_step(1'b0);
            check($sformatf("vec%0d_cnt", i),  int'(cnt),      vecs[i].e_cnt);
            check($sformatf("vec%0d_rep", i),  int'(rep_left), vecs[i].e_rep);
            check($sformatf("vec%0d_ack", i),  int'(ack),      vecs[i].e_ack);
            check($sformatf("vec%0d_busy", i), int'(busy),     vecs[i].e_busy);
            check($sformatf("vec%0d_tick", i), int'(tick),     vecs[i].e_tick);
            check($sformatf("vec%0d_done", i), int'(done),     vecs[i].e_done);
        end
        start = 1'b0;

        // limit 0, reps 0: one RUN cycle then DONE
        cfg_limit = 4'd0; cfg_reps = 4'd0; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        check("l0_run_busy", int'(busy), 1);
        check("l0_run_ack",  int'(ack),  1);
        check("l0_run_cnt",  int'(cnt),  0);
        clk_step(1'b0);
        check("l0_done",      int'(done), 1);
        check("l0_done_tick", int'(tick), 1);
        check("l0_done_busy", int'(busy), 0);
        clk_step(1'b0);
        check("l0_idle_done", int'(done), 0);
        check("l0_idle_tick", int'(tick), 0);

        // limit 5, stop at cnt=2, then restart and run to completion
        cfg_limit = 4'd5; cfg_reps = 4'd0; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        clk_step(1'b0);
        clk_step(1'b0);
        check("stop2_pre_cnt", int'(cnt), 2);
        stop = 1'b1;
        clk_step(1'b0);
        stop = 1'b0;
        check("stop2_busy", int'(busy), 0);
        check("stop2_cnt",  int'(cnt),  0);
        check("stop2_tick", int'(tick), 0);
        check("stop2_done", int'(done), 0);
        clk_step(1'b0);
        check("stop2_late_done", int'(done), 0);
        start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        check("restart_cnt", int'(cnt), 0);
        check("restart_ack", int'(ack), 1);
        repeat (6) clk_step(1'b0);
        check("restart_done", int'(done), 1);
        clk_step(1'b0);

        // limit 3, reps 0, stop on the would-be wrap cycle
        cfg_limit = 4'd3; cfg_reps = 4'd0; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        repeat (3) clk_step(1'b0);
        check("stopw_pre_cnt", int'(cnt), 3);
        stop = 1'b1;
        clk_step(1'b0);
        stop = 1'b0;
        check("stopw_tick", int'(tick), 0);
        check("stopw_done", int'(done), 0);
        check("stopw_busy", int'(busy), 0);

        // limit 7, asynchronous reset between edges at cnt=4
        cfg_limit = 4'd7; cfg_reps = 4'd2; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        repeat (4) clk_step(1'b0);
        check("arst_pre_cnt", int'(cnt), 4);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_cnt",  int'(cnt),      0);
        check("arst_busy", int'(busy),     0);
        check("arst_rep",  int'(rep_left), 0);
        #1 reset_n = 1'b1;
        repeat (10) clk_step(1'b1);

`ifdef CNT_CTRL_PAUSE_EN
        // limit 3, reps 0, pause for three edges at cnt=1 delays done by three cycles
        cfg_limit = 4'd3; cfg_reps = 4'd0; start = 1'b1;
        clk_step(1'b0);
        start = 1'b0;
        clk_step(1'b0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step(1'b0);
            check($sformatf("pause%0d_cnt", i),  int'(cnt),  1);
            check($sformatf("pause%0d_busy", i), int'(busy), 1);
        end
        pause = 1'b0;
        clk_step(1'b0);
        clk_step(1'b0);
        check("pause_pre_done", int'(done), 0);
        clk_step(1'b0);
        check("pause_done", int'(done), 1);
        clk_step(1'b0);
`endif

        // full-range limit then random traffic against the model
        cfg_limit = 4'd15; cfg_reps = 4'd0; start = 1'b1;
        clk_step(1'b1);
        start = 1'b0;
        repeat (18) clk_step(1'b1);
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 24) == 0;
            pause     = ($urandom % 6) == 0;
            cfg_limit = CNT_W'(($urandom % 3 == 0) ? $urandom % 16 : $urandom % 4);
            cfg_reps  = CNT_W'(($urandom % 5 == 0) ? $urandom % 16 : $urandom % 3);
            clk_step(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
